// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery iteration controller.
//   state_t   : controller FSM states (SUB/CHK only reachable when
//               MONT_FINAL_SUB_EN is defined)
//   SEL_*     : addend-select codes, indexed by {a_i, q}
//   ADD_W     : adder datapath width for the default 512-bit operand size
package mont_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOOP,
    SUB,
    CHK,
    DONE
  } state_t;

  // {a_i, q} -> addend
  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_M    = 2'b01;
  localparam logic [1:0] SEL_B    = 2'b10;
  localparam logic [1:0] SEL_BM   = 2'b11;

  localparam int WIDTH_DEF = 512;
  localparam int ADD_W     = WIDTH_DEF + 2;

endpackage

// File: rtl/mont_addend_mux.sv
// Combinational addend selector for the mpadder.
// Ports:
//   a_i, q   : current multiplier bit and Montgomery quotient bit
//   b, m     : latched multiplicand and modulus (WIDTH bits)
//   bm       : precomputed B+M (WIDTH+1 bits)
//   add_in_a : zero-extended addend (WIDTH+2 bits)
module mont_addend_mux
  import mont_pkg::*;
#(
  parameter int WIDTH = 512
) (
  input  logic             a_i,
  input  logic             q,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH:0]   bm,
  output logic [WIDTH+1:0] add_in_a
);

  always_comb begin
    add_in_a = '0;
    case ({a_i, q})
      SEL_B:   add_in_a = {2'b00, b};
      SEL_M:   add_in_a = {2'b00, m};
      SEL_BM:  add_in_a = {1'b0, bm};
      default: add_in_a = '0;
    endcase
  end

endmodule

// File: rtl/mont_iter_ctrl.sv
// Control/operand stage in front of mpadder for a bit-serial Montgomery
// multiply: result = A*B*2^-WIDTH mod M, left in the mpadder accumulator.
// Optional macro: MONT_FINAL_SUB_EN adds a final conditional subtract of M
// (SUB/CHK states) so the result lands in [0, M); without it the result is
// in [0, 2M), add_sub is tied low and add_borrow is ignored.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   start                  : operation request, sampled in IDLE only
//   in_a, in_b, in_m       : operands, latched when start is accepted
//   add_c_lsb, add_borrow  : accumulator bit 0 and sign after subtract
//   add_in_a               : addend to mpadder (WIDTH+2 bits)
//   add_clear/enable/shift/sub : mpadder strobes
//   busy, done             : operation in flight / one-cycle completion
module mont_iter_ctrl
  import mont_pkg::*;
#(
  parameter int WIDTH = 512,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  input  logic             add_c_lsb,
  input  logic             add_borrow,
  output logic [WIDTH+1:0] add_in_a,
  output logic             add_clear,
  output logic             add_enable,
  output logic             add_shift,
  output logic             add_sub,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] m_r;
  logic [WIDTH:0]   bm_r;
  logic [CNT_W-1:0] cnt;
  logic             en_r;
  logic             mux_a;
  logic             mux_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_r       <= '0;
      m_r       <= '0;
      bm_r      <= '0;
      cnt       <= '0;
      en_r      <= 1'b0;
      add_clear <= 1'b0;
      add_shift <= 1'b0;
`ifdef MONT_FINAL_SUB_EN
      add_sub   <= 1'b0;
`endif
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr      <= in_a;
            b_r       <= in_b;
            m_r       <= in_m;
            bm_r      <= {1'b0, in_b} + {1'b0, in_m};
            add_clear <= 1'b1;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          cnt       <= '0;
          add_clear <= 1'b0;
          en_r      <= 1'b1;
          add_shift <= 1'b1;
          state     <= LOOP;
        end
        LOOP: begin
          a_sr <= a_sr >> 1;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            add_shift <= 1'b0;
`ifdef MONT_FINAL_SUB_EN
            // en_r stays high: SUB accumulates C - M
            add_sub <= 1'b1;
            state   <= SUB;
`else
            en_r  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
`endif
          end
        end
`ifdef MONT_FINAL_SUB_EN
        SUB: begin
          en_r    <= 1'b0;
          add_sub <= 1'b0;
          state   <= CHK;
        end
        CHK: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
`endif
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Addend select must react to the live accumulator LSB (and to the live
  // borrow in CHK), so {a_i, q} is decoded combinationally from the state.
  always_comb begin
    mux_a = 1'b0;
    mux_q = 1'b0;
    case (state)
      LOOP: begin
        mux_a = a_sr[0];
        mux_q = add_c_lsb ^ (a_sr[0] & b_r[0]);
      end
`ifdef MONT_FINAL_SUB_EN
      SUB: mux_q = 1'b1;
      CHK: mux_q = add_borrow;
`endif
      default: ;
    endcase
  end

`ifdef MONT_FINAL_SUB_EN
  // CHK restores C by adding M back only when C - M went negative
  assign add_enable = en_r | ((state == CHK) & add_borrow);
`else
  logic unused_borrow;
  assign unused_borrow = add_borrow;
  assign add_sub       = 1'b0;
  assign add_enable    = en_r;
`endif

  mont_addend_mux #(
    .WIDTH(WIDTH)
  ) u_addend_mux (
    .a_i      (mux_a),
    .q        (mux_q),
    .b        (b_r),
    .m        (m_r),
    .bm       (bm_r),
    .add_in_a (add_in_a)
  );

endmodule

// File: tb/tb_mont_iter_ctrl.sv
`timescale 1ns/1ps
module tb_mont_iter_ctrl;

`ifdef MONT_FINAL_SUB_EN
  localparam int EXTRA = 4;
`else
  localparam int EXTRA = 2;
`endif

  typedef struct {
    bit           big;
    logic [511:0] a, b, m, r_exp;
    bit           has_exp;
  } vec_t;

  typedef struct {
    vec_t v;
    int   t0;
    int   lat;
  } sb_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;

  // ---------------- WIDTH=4 instance + mpadder model ----------------
  logic         start4 = 1'b0;
  logic [3:0]   a4 = '0, b4 = '0, m4 = '0;
  logic         lsb4, bor4;
  logic [5:0]   ina4, c4;
  logic         clr4, en4, sh4, sub4, busy4, done4;

  mont_iter_ctrl #(.WIDTH(4), .CNT_W(3)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .in_a(a4), .in_b(b4), .in_m(m4),
    .add_c_lsb(lsb4), .add_borrow(bor4), .add_in_a(ina4), .add_clear(clr4),
    .add_enable(en4), .add_shift(sh4), .add_sub(sub4), .busy(busy4), .done(done4)
  );

  assign lsb4 = c4[0];
  assign bor4 = c4[5];
  always @(posedge clk) begin
    if (reset || clr4) c4 <= '0;
    else if (en4) begin
      if (sub4)     c4 <= c4 - ina4;
      else if (sh4) c4 <= (c4 + ina4) >> 1;
      else          c4 <= c4 + ina4;
    end
  end

  // ---------------- WIDTH=512 instance + mpadder model ----------------
  logic         start5 = 1'b0;
  logic [511:0] a5 = '0, b5 = '0, m5 = '0;
  logic         lsb5, bor5;
  logic [513:0] ina5, c5;
  logic         clr5, en5, sh5, sub5, busy5, done5;

  mont_iter_ctrl #(.WIDTH(512), .CNT_W(10)) dut5 (
    .clk(clk), .reset(reset), .start(start5), .in_a(a5), .in_b(b5), .in_m(m5),
    .add_c_lsb(lsb5), .add_borrow(bor5), .add_in_a(ina5), .add_clear(clr5),
    .add_enable(en5), .add_shift(sh5), .add_sub(sub5), .busy(busy5), .done(done5)
  );

  assign lsb5 = c5[0];
  assign bor5 = c5[513];
  always @(posedge clk) begin
    if (reset || clr5) c5 <= '0;
    else if (en5) begin
      if (sub5)     c5 <= c5 - ina5;
      else if (sh5) c5 <= (c5 + ina5) >> 1;
      else          c5 <= c5 + ina5;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [519:0] act, input logic [519:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_result(input string tag, input logic [513:0] r, input vec_t v, input int w);
    logic [1535:0] rx, ax, bx, mx, lhs, rhs;
    logic [513:0]  m_ext;
    rx = 1536'(r);
    ax = 1536'(v.a);
    bx = 1536'(v.b);
    mx = 1536'(v.m);
    m_ext = 514'(v.m);
    lhs = (rx << w) % mx;
    rhs = (ax * bx) % mx;
    chk({tag, " congruence"}, 520'(lhs), 520'(rhs));
`ifdef MONT_FINAL_SUB_EN
    chk({tag, " range <M"}, 520'(r < m_ext), 520'(1));
    if (v.has_exp) chk({tag, " value"}, 520'(r), 520'(v.r_exp));
`else
    chk({tag, " range <2M"}, 520'(r < (m_ext << 1)), 520'(1));
    if (v.has_exp) chk({tag, " value mod M"}, 520'(rx % mx), 520'(v.r_exp));
`endif
  endtask

  sb_t q4[$], q5[$];
  int  acc4 = 0, acc5 = 0, done_cnt4 = 0, done_cnt5 = 0;
  int  clr_cnt4 = 0, sub_cyc = 0, k4 = 0, k5 = 0, trace_err = 0;
  logic [511:0] cur_a5 = '0, cur_b5 = '0, cur_m5 = '0;

  // Completion monitor / scoreboard pop, WIDTH=4
  always @(negedge clk) begin
    sb_t e;
    if (clr4) begin k4 = 0; clr_cnt4++; end
    if (en4 && sh4) k4++;
    if (sub4 || sub5) sub_cyc++;
    if (done4) begin
      done_cnt4++;
      if (q4.size() == 0) chk("dut4 unexpected done", 520'(1), 520'(0));
      else begin
        e = q4.pop_front();
        chk("dut4 latency", 520'(cyc - e.t0 + 1), 520'(e.lat));
        chk("dut4 loop cycles", 520'(k4), 520'(4));
        check_result("dut4", 514'(c4), e.v, 4);
      end
    end
  end

  // Completion monitor + per-cycle addend trace, WIDTH=512
  always @(negedge clk) begin
    sb_t e;
    logic ai, qq;
    logic [513:0] expa;
    if (clr5) k5 = 0;
    if (en5 && sh5) begin
      ai = (k5 < 512) ? cur_a5[k5] : 1'b0;
      qq = c5[0] ^ (ai & cur_b5[0]);
      case ({ai, qq})
        2'b10:   expa = 514'(cur_b5);
        2'b01:   expa = 514'(cur_m5);
        2'b11:   expa = 514'(cur_b5) + 514'(cur_m5);
        default: expa = '0;
      endcase
      if (ina5 !== expa) trace_err++;
      k5++;
    end
    if (done5) begin
      done_cnt5++;
      if (q5.size() == 0) chk("dut512 unexpected done", 520'(1), 520'(0));
      else begin
        e = q5.pop_front();
        chk("dut512 latency", 520'(cyc - e.t0 + 1), 520'(e.lat));
        chk("dut512 loop cycles", 520'(k5), 520'(512));
        check_result("dut512", c5, e.v, 512);
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic run_op(input vec_t v, input bit hold, output int t0);
    sb_t e;
    @(negedge clk);
    if (v.big) begin
      a5 = v.a; b5 = v.b; m5 = v.m; start5 = 1'b1;
      cur_a5 = v.a; cur_b5 = v.b; cur_m5 = v.m;
    end else begin
      a4 = v.a[3:0]; b4 = v.b[3:0]; m4 = v.m[3:0]; start4 = 1'b1;
    end
    @(posedge clk);
    #1;
    t0 = cyc;
    e.v = v; e.t0 = t0; e.lat = (v.big ? 512 : 4) + EXTRA;
    if (v.big) begin q5.push_back(e); acc5++; end
    else       begin q4.push_back(e); acc4++; end
    if (!hold) begin
      @(negedge clk);
      start4 = 1'b0;
      start5 = 1'b0;
    end
  endtask

  task automatic wait_q(input bit big, input int budget);
    int n = 0;
    while ((big ? q5.size() : q4.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if ((big ? q5.size() : q4.size()) != 0) begin
      chk(big ? "dut512 done timeout" : "dut4 done timeout", 520'(1), 520'(0));
      if (big) q5.delete(); else q4.delete();
    end
  endtask

  vec_t vecs[$];

  initial begin
    vec_t v;
    sb_t  e;
    int   t0, dn;
    logic [511:0] mr;

    // {big, a, b, m, r_exp, has_exp}
    vecs.push_back('{0, 512'd5,  512'd7,  512'd11, 512'd7, 1});
    vecs.push_back('{0, 512'd3,  512'd4,  512'd13, 512'd4, 1});
    vecs.push_back('{0, 512'd15, 512'd14, 512'd15, 512'd0, 1});
    vecs.push_back('{0, 512'd0,  512'd8,  512'd9,  512'd0, 1});
    vecs.push_back('{0, 512'd7,  512'd2,  512'd3,  512'd2, 1});
    mr = rnd512() | {1'b1, 510'd0, 1'b1};
    vecs.push_back('{1, 512'd0, rnd512() & {1'b0, {511{1'b1}}}, mr, 512'd0, 1});
    mr = rnd512() | {1'b1, 510'd0, 1'b1};
    vecs.push_back('{1, mr - 512'd1, mr - 512'd1, mr, 512'd0, 0});

    // Reset state
    repeat (3) @(negedge clk);
    chk("dut4 reset strobes", 520'({clr4, en4, sh4, sub4, busy4, done4}), 520'(0));
    chk("dut4 reset addend", 520'(ina4), 520'(0));
    chk("dut512 reset strobes", 520'({clr5, en5, sh5, sub5, busy5, done5}), 520'(0));
    chk("dut512 reset addend", 520'(ina5), 520'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven vectors
    foreach (vecs[i]) begin
      run_op(vecs[i], 1'b0, t0);
      wait_q(vecs[i].big, 700);
    end

    // start during LOOP is ignored
    run_op(vecs[0], 1'b0, t0);
    repeat (2) @(negedge clk);
    a4 = 4'd3; b4 = 4'd4; m4 = 4'd13; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    wait_q(1'b0, 40);
    repeat (12) @(negedge clk);
    chk("dut4 busy idle after op", 520'(busy4), 520'(0));

    // Back-to-back with start held high
    run_op(vecs[1], 1'b1, t0);
    e.v = vecs[1]; e.t0 = t0 + 4 + EXTRA + 1; e.lat = 4 + EXTRA;
    q4.push_back(e);
    acc4++;
    while (cyc < t0 + 4 + EXTRA + 1) @(negedge clk);
    start4 = 1'b0;
    wait_q(1'b0, 60);
    repeat (10) @(negedge clk);

    // Reset mid-operation at cycle 100 of a 512-bit op
    v = vecs[6];
    @(negedge clk);
    a5 = v.a; b5 = v.b; m5 = v.m; start5 = 1'b1;
    cur_a5 = v.a; cur_b5 = v.b; cur_m5 = v.m;
    @(posedge clk);
    #1;
    t0 = cyc;
    @(negedge clk);
    start5 = 1'b0;
    while (cyc < t0 + 99) @(negedge clk);
    dn = done_cnt5;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("dut512 busy after reset", 520'(busy5), 520'(0));
    chk("dut512 enable/shift after reset", 520'({en5, sh5}), 520'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (600) @(negedge clk);
    chk("dut512 no done for aborted op", 520'(done_cnt5 - dn), 520'(0));

    // New op after the abort completes correctly
    v = vecs[6];
    v.a = rnd512() >> 1;
    v.b = v.m >> 2;
    run_op(v, 1'b0, t0);
    wait_q(1'b1, 700);

    repeat (5) @(negedge clk);
    chk("dut512 addend trace mismatches", 520'(trace_err), 520'(0));
    chk("dut4 done count", 520'(done_cnt4), 520'(acc4));
    chk("dut512 done count", 520'(done_cnt5), 520'(acc5));
    chk("dut4 add_clear pulses", 520'(clr_cnt4), 520'(acc4));
`ifdef MONT_FINAL_SUB_EN
    chk("add_sub cycles", 520'(sub_cyc), 520'(done_cnt4 + done_cnt5));
`else
    chk("add_sub cycles", 520'(sub_cyc), 520'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
